// File: rtl/irq_source_conditioner_if.sv
// Bus bundle between the interrupt source conditioner and its environment:
// the APB register port plus the interrupt controller handshake.
interface irq_source_conditioner_if #(
  parameter int NO_OF_PERIPHERALS = 8,
  parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS)
);
  // APB register access
  logic                         penable;
  logic                         pwrite;
  logic [1:0]                   paddr;
  logic [NO_OF_PERIPHERALS-1:0] pwdata;
  logic [NO_OF_PERIPHERALS-1:0] prdata;
  logic                         pready;

  // Interrupt controller side
  logic                         interrupt_valid;
  logic [WIDTH-1:0]             interrupt_to_be_service;
  logic                         interrupt_serviced;
  logic [NO_OF_PERIPHERALS-1:0] interrupt_active;

  modport master (
    output penable, pwrite, paddr, pwdata,
    output interrupt_valid, interrupt_to_be_service, interrupt_serviced,
    input  prdata, pready, interrupt_active
  );

  modport slave (
    input  penable, pwrite, paddr, pwdata,
    input  interrupt_valid, interrupt_to_be_service, interrupt_serviced,
    output prdata, pready, interrupt_active
  );
endinterface

// File: rtl/irq_source_conditioner.sv
// Interrupt source conditioner: synchronises raw interrupt lines, captures
// them per source as edge or level requests, masks them towards the interrupt
// controller and exposes MASK/MODE/PENDING/OVERRUN over a small APB port.
module irq_source_conditioner #(
  parameter int NO_OF_PERIPHERALS = 8,
  parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS)
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic [NO_OF_PERIPHERALS-1:0] irq_raw,
  irq_source_conditioner_if.slave      bus
);

  localparam int N = NO_OF_PERIPHERALS;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {
    REG_MASK    = 2'd0,
    REG_MODE    = 2'd1,
    REG_PENDING = 2'd2,
    REG_OVERRUN = 2'd3
  } reg_sel_e;

  logic [N-1:0] sync1_q, sync2_q, prev_q;
  logic [N-1:0] mask_q, mode_q, pending_q, overrun_q;
  logic [N-1:0] prdata_q, active_q;
  logic         pready_q;

  logic [N-1:0] mask_d, mode_d, pending_d, overrun_d, prdata_d;
  logic [N-1:0] rise, svc_clr, w1c_pend, w1c_ovr, clr, mode_chg;
  logic [WIDTH-1:0] svc_idx;
  logic         wr_en, rd_en;
  reg_sel_e     sel;

  assign svc_idx = bus.interrupt_to_be_service;

  // Register access decode, clear-event sources and register next values
  always_comb begin
    sel      = reg_sel_e'(bus.paddr);
    wr_en    = bus.penable & bus.pwrite;
    rd_en    = bus.penable & ~bus.pwrite;
    rise     = sync2_q & ~prev_q;
    // An index >= N shifts the single bit out of range and clears nothing.
    svc_clr  = (bus.interrupt_valid & bus.interrupt_serviced) ? (ONE << svc_idx) : '0;
    w1c_pend = (wr_en && sel == REG_PENDING) ? bus.pwdata : '0;
    w1c_ovr  = (wr_en && sel == REG_OVERRUN) ? bus.pwdata : '0;
    clr      = svc_clr | w1c_pend;
    mask_d   = (wr_en && sel == REG_MASK) ? bus.pwdata : mask_q;
    mode_d   = (wr_en && sel == REG_MODE) ? bus.pwdata : mode_q;
    mode_chg = mode_d ^ mode_q;
    prdata_d = prdata_q;
    if (rd_en) begin
      case (sel)
        REG_MASK:    prdata_d = mask_q;
        REG_MODE:    prdata_d = mode_q;
        REG_PENDING: prdata_d = pending_q;
        REG_OVERRUN: prdata_d = overrun_q;
        default:     prdata_d = '0;
      endcase
    end
  end

  // Per-source capture: mode change first, then level follow, then edge rules
  always_comb begin
    pending_d = pending_q;
    // Overrun W1C is applied before a new overrun so a same-cycle event is kept.
    overrun_d = overrun_q & ~w1c_ovr;
    for (int unsigned i = 0; i < N; i++) begin
      if (mode_chg[i]) begin
        pending_d[i] = ~mode_d[i] & sync2_q[i];
        overrun_d[i] = 1'b0;
      end else if (!mode_q[i]) begin
        pending_d[i] = sync2_q[i];
      end else if (rise[i]) begin
        pending_d[i] = 1'b1;
        if (pending_q[i] && !clr[i]) overrun_d[i] = 1'b1;
      end else if (clr[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // State registers; reset overrides everything
  always_ff @(posedge pclk) begin
    if (preset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      active_q  <= '0;
    end else begin
      sync1_q   <= irq_raw;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      prdata_q  <= prdata_d;
      pready_q  <= bus.penable;
      active_q  <= pending_d & mask_d;
    end
  end

  assign bus.prdata           = prdata_q;
  assign bus.pready           = pready_q;
  assign bus.interrupt_active = active_q;

endmodule

// File: tb/tb_irq_source_conditioner.sv
// Self-checking bench for irq_source_conditioner: a register-access vector
// table, hand-written multi-cycle scenarios, and a randomized phase compared
// against a behavioural reference model.
module tb_irq_source_conditioner;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic [7:0] irq_raw = '0;

  irq_source_conditioner_if #(.NO_OF_PERIPHERALS(8)) bus ();

  irq_source_conditioner #(.NO_OF_PERIPHERALS(8)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .irq_raw (irq_raw),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // raw_hist[k] is irq_raw as sampled k+1 edges ago (cleared by reset).
  logic [7:0] raw_hist [3];
  logic [7:0] m_mask = '0, m_mode = '0, m_pend = '0, m_ovr = '0;
  logic [7:0] m_rd = '0, m_act = '0;
  logic       m_rdy = 1'b0;

  always @(posedge pclk) begin : model
    logic [7:0] nmask, nmode, npend, novr, clr, s2, pv;
    logic       wr;
    if (preset) begin
      for (int k = 0; k < 3; k++) raw_hist[k] = '0;
      m_mask = '0; m_mode = '0; m_pend = '0; m_ovr = '0;
      m_rd = '0; m_act = '0; m_rdy = 1'b0;
    end else begin
      wr = bus.penable && bus.pwrite;
      if (bus.penable && !bus.pwrite)
        m_rd = (bus.paddr == 2'd0) ? m_mask :
               (bus.paddr == 2'd1) ? m_mode :
               (bus.paddr == 2'd2) ? m_pend : m_ovr;
      nmask = (wr && bus.paddr == 2'd0) ? bus.pwdata : m_mask;
      nmode = (wr && bus.paddr == 2'd1) ? bus.pwdata : m_mode;
      novr  = (wr && bus.paddr == 2'd3) ? (m_ovr & ~bus.pwdata) : m_ovr;
      npend = m_pend;
      s2 = raw_hist[1];
      pv = raw_hist[2];
      for (int i = 0; i < 8; i++) begin
        clr[i] = (bus.interrupt_valid && bus.interrupt_serviced &&
                  int'(bus.interrupt_to_be_service) == i) ||
                 (wr && bus.paddr == 2'd2 && bus.pwdata[i]);
        if (nmode[i] != m_mode[i]) begin
          novr[i]  = 1'b0;
          npend[i] = nmode[i] ? 1'b0 : s2[i];
        end else if (m_mode[i] == 1'b0) begin
          npend[i] = s2[i];
        end else if (s2[i] && !pv[i]) begin
          if (m_pend[i] && !clr[i]) novr[i] = 1'b1;
          npend[i] = 1'b1;
        end else if (clr[i]) begin
          npend[i] = 1'b0;
        end
      end
      raw_hist[2] = raw_hist[1];
      raw_hist[1] = raw_hist[0];
      raw_hist[0] = irq_raw;
      m_mask = nmask; m_mode = nmode; m_pend = npend; m_ovr = novr;
      m_act  = npend & nmask;
      m_rdy  = bus.penable;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // One APB access held for a single edge; pready must follow on that edge.
  task automatic apb(input logic wr, input logic [1:0] a, input logic [7:0] d,
                     output logic [7:0] rd);
    bus.penable = 1'b1;
    bus.pwrite  = wr;
    bus.paddr   = a;
    bus.pwdata  = d;
    step();
    rd = bus.prdata;
    chk("pready_ack", {7'b0, bus.pready}, 8'h01);
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic pulse(input int b);
    irq_raw[b] = 1'b1;
    steps(2);
    irq_raw[b] = 1'b0;
    steps(4);
  endtask

  task automatic service(input logic [2:0] idx);
    bus.interrupt_valid         = 1'b1;
    bus.interrupt_to_be_service = idx;
    bus.interrupt_serviced      = 1'b1;
  endtask

  task automatic service_off();
    bus.interrupt_valid    = 1'b0;
    bus.interrupt_serviced = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] rd;

    tbl[0] = '{1'b0, 2'd0, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 2'd1, 8'h00, 8'h00};
    tbl[2] = '{1'b0, 2'd2, 8'h00, 8'h00};
    tbl[3] = '{1'b0, 2'd3, 8'h00, 8'h00};
    tbl[4] = '{1'b1, 2'd0, 8'hA5, 8'h00};
    tbl[5] = '{1'b0, 2'd0, 8'h00, 8'hA5};
    tbl[6] = '{1'b1, 2'd0, 8'hFF, 8'h00};
    tbl[7] = '{1'b0, 2'd0, 8'h00, 8'hFF};
    tbl[8] = '{1'b1, 2'd1, 8'h01, 8'h00};
    tbl[9] = '{1'b0, 2'd1, 8'h00, 8'h01};

    bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    bus.interrupt_valid = 1'b0; bus.interrupt_to_be_service = '0;
    bus.interrupt_serviced = 1'b0;

    // Reset state
    steps(3);
    preset = 1'b0;
    chk("rst_active", bus.interrupt_active, 8'h00);
    chk("rst_pready", {7'b0, bus.pready}, 8'h00);
    chk("rst_prdata", bus.prdata, 8'h00);

    // Register access table
    for (int v = 0; v < 10; v++) begin
      apb(tbl[v].wr, tbl[v].addr, tbl[v].data, rd);
      if (!tbl[v].wr) chk($sformatf("tbl%0d_rd", v), rd, tbl[v].exp_rd);
      chk($sformatf("tbl%0d_act", v), bus.interrupt_active, 8'h00);
    end
    step();
    chk("pready_drop", {7'b0, bus.pready}, 8'h00);

    // Edge capture on bit 0, latency and service clear
    irq_raw[0] = 1'b1;
    step();
    step();
    chk("edge0_k1", bus.interrupt_active, 8'h00);
    irq_raw[0] = 1'b0;
    step();
    chk("edge0_k2", bus.interrupt_active, 8'h01);
    steps(3);
    chk("edge0_held", bus.interrupt_active, 8'h01);
    service(3'd0);
    step();
    service_off();
    chk("edge0_svc", bus.interrupt_active, 8'h00);

    // Level mode, mask 0x08: bit 3 held 5 cycles
    apb(1'b1, 2'd1, 8'h00, rd);
    apb(1'b1, 2'd0, 8'h08, rd);
    irq_raw[3] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("lvl3_c%0d", c), bus.interrupt_active,
          (c >= 2 && c <= 6) ? 8'h08 : 8'h00);
      if (c == 4) irq_raw[3] = 1'b0;
    end
    irq_raw[4] = 1'b1;
    steps(3);
    chk("lvl4_masked", bus.interrupt_active, 8'h00);
    apb(1'b0, 2'd2, 8'h00, rd);
    chk("lvl4_pending", rd, 8'h10);
    irq_raw[4] = 1'b0;
    steps(4);

    // Edge bit 2: overrun, overrun W1C, pending W1C
    apb(1'b1, 2'd1, 8'h04, rd);
    apb(1'b1, 2'd0, 8'hFF, rd);
    pulse(2);
    chk("ovr2_first", bus.interrupt_active, 8'h04);
    pulse(2);
    apb(1'b0, 2'd3, 8'h00, rd);
    chk("ovr2_set", rd, 8'h04);
    apb(1'b1, 2'd3, 8'h04, rd);
    apb(1'b0, 2'd3, 8'h00, rd);
    chk("ovr2_w1c", rd, 8'h00);
    chk("pend2_before", bus.interrupt_active, 8'h04);
    apb(1'b1, 2'd2, 8'h04, rd);
    chk("pend2_w1c", bus.interrupt_active, 8'h00);

    // Edge bit 1: rise coinciding with a service clear
    apb(1'b1, 2'd1, 8'h06, rd);
    pulse(1);
    irq_raw[1] = 1'b1;
    step();
    step();
    service(3'd1);
    step();
    service_off();
    irq_raw[1] = 1'b0;
    steps(3);
    apb(1'b0, 2'd2, 8'h00, rd);
    chk("coinc_pending", rd, 8'h02);
    apb(1'b0, 2'd3, 8'h00, rd);
    chk("coinc_overrun", rd, 8'h00);
    service(3'd1);
    step();
    service_off();
    chk("coinc_svc", bus.interrupt_active, 8'h00);

    // Reset mid-operation with bit 7 held high in edge mode
    apb(1'b1, 2'd1, 8'hFF, rd);
    irq_raw = 8'hA5;
    steps(2);
    irq_raw = 8'h80;
    steps(3);
    apb(1'b0, 2'd2, 8'h00, rd);
    chk("pre_rst_pending", rd, 8'hA5);
    chk("pre_rst_active", bus.interrupt_active, 8'hA5);
    preset = 1'b1;
    step();
    chk("mid_rst_active", bus.interrupt_active, 8'h00);
    chk("mid_rst_prdata", bus.prdata, 8'h00);
    chk("mid_rst_pready", {7'b0, bus.pready}, 8'h00);
    preset = 1'b0;
    apb(1'b1, 2'd1, 8'h80, rd);
    apb(1'b1, 2'd0, 8'h80, rd);
    chk("post_rst_r2", bus.interrupt_active, 8'h00);
    step();
    chk("post_rst_r3", bus.interrupt_active, 8'h80);
    steps(3);
    apb(1'b0, 2'd2, 8'h00, rd);
    chk("post_rst_pending", rd, 8'h80);
    apb(1'b0, 2'd3, 8'h00, rd);
    chk("post_rst_overrun", rd, 8'h00);
    irq_raw = '0;

    // Randomized phase against the reference model
    preset = 1'b1;
    steps(2);
    preset = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) irq_raw[b] = ~irq_raw[b];
      preset                      = ($urandom_range(0, 299) == 0);
      bus.penable                 = ($urandom_range(0, 2) == 0);
      bus.pwrite                  = 1'($urandom);
      bus.paddr                   = 2'($urandom);
      bus.pwdata                  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      bus.interrupt_valid         = 1'($urandom);
      bus.interrupt_serviced      = ($urandom_range(0, 3) == 0);
      bus.interrupt_to_be_service = 3'($urandom);
      step();
      chk("rnd_active", bus.interrupt_active, m_act);
      chk("rnd_pready", {7'b0, bus.pready}, {7'b0, m_rdy});
      chk("rnd_prdata", bus.prdata, m_rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
